compress_arbiter: RTL and testbench
===================================

Name: compress_arbiter

Overview:
- Shares one compress_unit among NUM_REQ requesting streams.
- Grants one requester at a time for a whole burst, terminated by req_last.
- Feeds the burst to the unit, waits for the unit to drain to idle, then re-arbitrates round-robin.
- Returns unit results tagged with the owning requester id; a hung unit is detected by a drain timeout.

Parameters:
NUM_REQ, 4, number of requesters
DATA_W, 32, data word width (matches compress_unit)
ID_W, 2, requester id width, clog2(NUM_REQ)
DRAIN_TIMEOUT, 64, max DRAIN cycles before error abort

Ports:
clk  in  1  clock; all logic on rising edge
resetn  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester word valid
req_last  in  NUM_REQ  per-requester last word of burst
req_data  in  NUM_REQ*DATA_W  per-requester word; requester i uses bits [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  per-requester accept
cu_enable  out  1  to compress_unit enable
cu_data_in  out  DATA_W  to compress_unit data_in
cu_data_out  in  DATA_W  from compress_unit data_out
cu_status  in  2  from compress_unit: 00 idle, 01 busy, 10 output valid, 11 output valid+busy
out_valid  out  1  result word valid (single-cycle, no backpressure)
out_data  out  DATA_W  result word
out_id  out  ID_W  owner of out_data
busy  out  1  state != IDLE
grant_id  out  ID_W  current or last owner
timeout_err  out  1  one-cycle pulse on drain timeout

Behaviour:
- Reset (resetn=0, async): state=IDLE; rr_ptr=0; grant_id=0; drain counter=0; cu_enable=0; cu_data_in=0; out_valid=0; out_data=0; out_id=0; timeout_err=0. req_ready=0 in reset.
- Reset mid-burst: aborts immediately. The partial burst is lost. The requester must restart after resetn=1.
- States: IDLE, STREAM, DRAIN.
- IDLE:
  - If any req_valid, select the first requester at or after rr_ptr, searching upward with wrap (rr_ptr, rr_ptr+1, ..., modulo NUM_REQ).
  - Load grant_id and go to STREAM next cycle. Arbitration takes 1 cycle.
  - No req_valid: stay in IDLE.
- STREAM:
  - req_ready[grant_id]=1, all other bits 0; req_ready is combinational from registered state and grant_id.
  - A transfer occurs when req_valid[g] & req_ready[g].
  - On a transfer: next cycle cu_enable=1 and cu_data_in=that word (1-cycle registered pipeline). With no transfer: cu_enable=0 and cu_data_in holds its value.
  - A transfer with req_last[g]=1 -> DRAIN next cycle.
  - Requester gaps (valid low) are allowed: stay in STREAM.
- DRAIN:
  - req_ready all 0; cu_enable=0 after the final registered word has been issued.
  - Drain counter starts at 0 and increments each cycle.
  - Exit when counter>=2 and cu_status==00: go to IDLE with rr_ptr=grant_id+1 (wraps to 0 after NUM_REQ-1).
  - If counter reaches DRAIN_TIMEOUT-1 without exit: pulse timeout_err for 1 cycle, go to IDLE, advance rr_ptr the same way.
- Result path (registered, 1-cycle latency):
  - out_valid=cu_status[1] & (state != IDLE); out_data=cu_data_out; out_id=grant_id.
  - cu_status[1] observed in IDLE is discarded (out_valid=0).
- Fairness: a requester that is re-asserting valid is not regranted while any other requester has valid high at arbitration time.
- Simultaneous events:
  - req_last transfer and cu_status output in the same cycle: both handled; the output is tagged with the current grant_id.
  - A single-word burst (first word has req_last) gives STREAM for 1 cycle, then DRAIN.
- grant_id holds its value in IDLE (last owner).

Test Plan:
1. Reset mid-STREAM: assert resetn=0 with req_valid[1]=1 in STREAM -> all outputs 0 immediately, state IDLE, rr_ptr=0; after release, requester 1 regranted.
2. Single requester: req 0 sends words 2, 101, 1001 (last on 1001) -> cu_enable high 3 cycles carrying 2, 101, 1001, each one cycle after its transfer; DRAIN entered; unit results appear as out_valid with out_id=0; return to IDLE when cu_status=00, rr_ptr=1.
3. Round-robin: all 4 req_valid held high, each sending a 2-word burst -> grant order 0, 1, 2, 3, 0; req_ready is never high for two requesters at once.
4. Gapped burst: req 2 sends a word, drops valid for 5 cycles, then sends its last word -> stays in STREAM through the gap, cu_enable=0 during the gap, DRAIN only after the last word.
5. Drain timeout: cu_status stuck at 01 after the last word -> timeout_err pulses exactly once at DRAIN cycle 63, then IDLE, and the next requester is granted.
6. Output during STREAM and single-word burst: cu_status=10 with cu_data_out=0xABCD while req 3 streams -> out_valid=1, out_data=0xABCD, out_id=3 one cycle later. A single-word burst (req_last on the first word) -> 1 STREAM cycle, then DRAIN.

Source files
------------

// File: rtl/compress_arbiter.sv
// Round-robin burst arbiter sharing one compress_unit among NUM_REQ streams.
// Grants whole bursts, drains the unit, and tags results with the owner id.
module compress_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 32,
    parameter int ID_W          = 2,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cu_enable,
    output logic [DATA_W-1:0]         cu_data_in,
    input  logic [DATA_W-1:0]         cu_data_out,
    input  logic [1:0]                cu_status,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_id,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      timeout_err
);

    localparam int CNT_W = $clog2(DRAIN_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cu_en_q, cu_en_d;
    logic [DATA_W-1:0]   cu_data_q, cu_data_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ID_W-1:0]     out_id_q, out_id_d;
    logic                timeout_q, timeout_d;

    logic [ID_W-1:0]     pick;
    logic                xfer;
    logic                xfer_last;
    logic [DATA_W-1:0]   gnt_data;
    logic [ID_W-1:0]     next_ptr;

    assign req_ready = (state_q == STREAM) ? (NUM_REQ'(1) << grant_q) : '0;
    assign xfer      = |(req_valid & req_ready);
    assign xfer_last = |(req_valid & req_last & req_ready);
    assign gnt_data  = req_data[int'(grant_q)*DATA_W +: DATA_W];
    assign next_ptr  = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int             idx;
        logic [ID_W-1:0] idx_id;
        logic           found;
        pick   = rr_ptr_q;
        found  = 1'b0;
        idx    = 0;
        idx_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_id = ID_W'(idx);
            if (!found && req_valid[idx_id]) begin
                pick  = idx_id;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        cu_en_d     = 1'b0;
        cu_data_d   = cu_data_q;
        timeout_d   = 1'b0;
        out_valid_d = cu_status[1] & (state_q != IDLE);
        out_data_d  = cu_data_out;
        out_id_d    = grant_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|req_valid) begin
                    grant_d = pick;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (xfer) begin
                    cu_en_d   = 1'b1;
                    cu_data_d = gnt_data;
                    if (xfer_last) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q >= CNT_W'(2) && cu_status == 2'b00) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    rr_ptr_d  = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            cu_en_q     <= 1'b0;
            cu_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            cu_en_q     <= cu_en_d;
            cu_data_q   <= cu_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cu_enable   = cu_en_q;
    assign cu_data_in  = cu_data_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_id      = out_id_q;
    assign busy        = (state_q != IDLE);
    assign grant_id    = grant_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_compress_arbiter.sv
// Directed bench for compress_arbiter: reset, streaming, round-robin,
// gapped bursts, drain timeout and result tagging.
module tb_compress_arbiter;

    logic         clk = 1'b0;
    logic         resetn;
    logic [3:0]   req_valid;
    logic [3:0]   req_last;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         cu_enable;
    logic [31:0]  cu_data_in;
    logic [31:0]  cu_data_out;
    logic [1:0]   cu_status;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_id;
    logic         busy;
    logic [1:0]   grant_id;
    logic         timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    compress_arbiter dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .cu_enable   (cu_enable),
        .cu_data_in  (cu_data_in),
        .cu_data_out (cu_data_out),
        .cu_status   (cu_status),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_id      (out_id),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid   = '0;
        req_last    = '0;
        req_data    = {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000};
        cu_data_out = '0;
        cu_status   = 2'b00;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 1'b0;
        #3;
        n_cmp++;
        if ({busy, cu_enable, out_valid, timeout_err} !== 4'b0000) begin
            $display("FAIL reset_flags got %b want 0000",
                     {busy, cu_enable, out_valid, timeout_err});
            n_bad++;
        end
        n_cmp++;
        if ({req_ready, grant_id, out_id} !== 8'h00) begin
            $display("FAIL reset_ids got %h want 00", {req_ready, grant_id, out_id});
            n_bad++;
        end
        n_cmp++;
        if ({cu_data_in, out_data} !== 64'h0) begin
            $display("FAIL reset_data got %h want 0", {cu_data_in, out_data});
            n_bad++;
        end
        tick();
        resetn = 1'b1;
        #1;
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        req_valid = 4'b0010;
        tick();
        tick();
        n_cmp++;
        if (req_ready !== 4'b0010 || cu_enable !== 1'b1) begin
            $display("FAIL rms_stream ready %b en %b want 0010 1", req_ready, cu_enable);
            n_bad++;
        end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({busy, cu_enable, req_ready, grant_id} !== 8'h00 || cu_data_in !== 32'h0) begin
            $display("FAIL rms_async got %b %b %b %d want all zero",
                     busy, cu_enable, req_ready, grant_id);
            n_bad++;
        end
        tick();
        resetn = 1'b1;
        req_valid = 4'b1010;
        tick();
        n_cmp++;
        if (grant_id !== 2'd1 || req_ready !== 4'b0010) begin
            $display("FAIL rms_regrant got id %0d ready %b want 1 0010", grant_id, req_ready);
            n_bad++;
        end
    endtask

    task automatic test_single_requester();
        do_reset();
        req_valid = 4'b0001;
        req_data[31:0] = 32'd2;
        tick();
        n_cmp++;
        if (req_ready !== 4'b0001 || grant_id !== 2'd0 || cu_enable !== 1'b0) begin
            $display("FAIL single_grant ready %b id %0d en %b", req_ready, grant_id, cu_enable);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (cu_enable !== 1'b1 || cu_data_in !== 32'd2) begin
            $display("FAIL single_w0 got %b %0d want 1 2", cu_enable, cu_data_in);
            n_bad++;
        end
        req_data[31:0] = 32'd101;
        tick();
        n_cmp++;
        if (cu_enable !== 1'b1 || cu_data_in !== 32'd101) begin
            $display("FAIL single_w1 got %b %0d want 1 101", cu_enable, cu_data_in);
            n_bad++;
        end
        req_data[31:0] = 32'd1001;
        req_last = 4'b0001;
        tick();
        n_cmp++;
        if (cu_enable !== 1'b1 || cu_data_in !== 32'd1001 || req_ready !== 4'b0000
            || busy !== 1'b1) begin
            $display("FAIL single_w2 got %b %0d ready %b busy %b want 1 1001 0000 1",
                     cu_enable, cu_data_in, req_ready, busy);
            n_bad++;
        end
        req_valid = '0;
        req_last = '0;
        cu_status = 2'b10;
        cu_data_out = 32'h0000_0055;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h55 || out_id !== 2'd0 || cu_enable !== 1'b0) begin
            $display("FAIL single_result got v%b d%h id%0d en%b want 1 55 0 0",
                     out_valid, out_data, out_id, cu_enable);
            n_bad++;
        end
        cu_status = 2'b01;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL single_busy got v%b busy%b want 0 1", out_valid, busy);
            n_bad++;
        end
        cu_status = 2'b00;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || grant_id !== 2'd0) begin
            $display("FAIL single_idle got busy %b id %0d want 0 0", busy, grant_id);
            n_bad++;
        end
        req_valid = 4'b0011;
        tick();
        n_cmp++;
        if (grant_id !== 2'd1) begin
            $display("FAIL single_rrptr got %0d want 1", grant_id);
            n_bad++;
        end
    endtask

    task automatic test_round_robin();
        int g;
        int w;
        logic [3:0] exp_r;
        do_reset();
        req_valid = 4'hF;
        for (int b = 0; b < 5; b++) begin
            g = b % 4;
            exp_r = 4'b0001 << g;
            w = 0;
            while (req_ready == 4'b0 && w < 10) begin
                tick();
                w++;
                n_cmp++;
                if ($countones(req_ready) > 1) begin
                    $display("FAIL rr_onehot got %b", req_ready);
                    n_bad++;
                end
            end
            n_cmp++;
            if (req_ready !== exp_r || grant_id !== 2'(g)) begin
                $display("FAIL rr_grant%0d got id %0d ready %b want %0d %b",
                         b, grant_id, req_ready, g, exp_r);
                n_bad++;
            end
            tick();
            n_cmp++;
            if (req_ready !== exp_r) begin
                $display("FAIL rr_word%0d got %b want %b", b, req_ready, exp_r);
                n_bad++;
            end
            req_last = 4'hF;
            tick();
            n_cmp++;
            if (req_ready !== 4'b0 || busy !== 1'b1) begin
                $display("FAIL rr_drain%0d got %b %b want 0000 1", b, req_ready, busy);
                n_bad++;
            end
            req_last = '0;
            w = 0;
            while (busy && w < 10) begin
                tick();
                w++;
            end
            n_cmp++;
            if (busy !== 1'b0) begin
                $display("FAIL rr_idle%0d got busy %b want 0", b, busy);
                n_bad++;
            end
        end
    endtask

    task automatic test_gapped_burst();
        do_reset();
        req_valid = 4'b0100;
        req_data[95:64] = 32'h0000_00AA;
        tick();
        tick();
        n_cmp++;
        if (cu_enable !== 1'b1 || cu_data_in !== 32'hAA) begin
            $display("FAIL gap_first got %b %h want 1 aa", cu_enable, cu_data_in);
            n_bad++;
        end
        req_valid = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (cu_enable !== 1'b0 || req_ready !== 4'b0100 || busy !== 1'b1
                || cu_data_in !== 32'hAA) begin
                $display("FAIL gap_hold%0d en %b ready %b busy %b d %h", i,
                         cu_enable, req_ready, busy, cu_data_in);
                n_bad++;
            end
        end
        req_valid = 4'b0100;
        req_last = 4'b0100;
        req_data[95:64] = 32'h0000_00BB;
        tick();
        n_cmp++;
        if (cu_enable !== 1'b1 || cu_data_in !== 32'hBB || req_ready !== 4'b0000) begin
            $display("FAIL gap_last got %b %h ready %b want 1 bb 0000",
                     cu_enable, cu_data_in, req_ready);
            n_bad++;
        end
    endtask

    task automatic test_drain_timeout();
        int pulses;
        int first;
        do_reset();
        req_valid = 4'b0001;
        req_last = 4'b0001;
        tick();
        tick();
        req_valid = '0;
        req_last = '0;
        cu_status = 2'b01;
        pulses = 0;
        first = -1;
        for (int t = 1; t <= 70; t++) begin
            tick();
            if (timeout_err === 1'b1) begin
                pulses++;
                if (first < 0) first = t;
            end
        end
        n_cmp++;
        if (pulses !== 1 || first !== 64) begin
            $display("FAIL timeout_pulse got %0d pulses at %0d want 1 at 64", pulses, first);
            n_bad++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            $display("FAIL timeout_idle got busy %b want 0", busy);
            n_bad++;
        end
        cu_status = 2'b00;
        req_valid = 4'b0011;
        tick();
        n_cmp++;
        if (grant_id !== 2'd1) begin
            $display("FAIL timeout_next got %0d want 1", grant_id);
            n_bad++;
        end
    endtask

    task automatic test_output_and_single_word();
        int w;
        do_reset();
        req_valid = 4'b1000;
        tick();
        tick();
        tick();
        n_cmp++;
        if (grant_id !== 2'd3 || req_ready !== 4'b1000) begin
            $display("FAIL out_grant got %0d %b want 3 1000", grant_id, req_ready);
            n_bad++;
        end
        cu_status = 2'b10;
        cu_data_out = 32'h0000_ABCD;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'hABCD || out_id !== 2'd3) begin
            $display("FAIL out_stream got v%b d%h id%0d want 1 abcd 3",
                     out_valid, out_data, out_id);
            n_bad++;
        end
        cu_status = 2'b10;
        cu_data_out = 32'h0000_1234;
        req_last = 4'b1000;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h1234 || out_id !== 2'd3
            || req_ready !== 4'b0000 || busy !== 1'b1) begin
            $display("FAIL out_lastsim got v%b d%h id%0d ready %b busy %b",
                     out_valid, out_data, out_id, req_ready, busy);
            n_bad++;
        end
        req_valid = '0;
        req_last = '0;
        cu_status = 2'b00;
        w = 0;
        while (busy && w < 10) begin
            tick();
            w++;
        end
        cu_status = 2'b10;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL out_idle_discard got v%b busy%b want 0 0", out_valid, busy);
            n_bad++;
        end
        cu_status = 2'b00;
        req_valid = 4'b0001;
        req_last = 4'b0001;
        tick();
        n_cmp++;
        if (busy !== 1'b1 || req_ready !== 4'b0001 || grant_id !== 2'd0) begin
            $display("FAIL sw_stream got busy %b ready %b id %0d", busy, req_ready, grant_id);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (busy !== 1'b1 || req_ready !== 4'b0000 || cu_enable !== 1'b1
            || cu_data_in !== 32'hD0D0_0000) begin
            $display("FAIL sw_drain got busy %b ready %b en %b d %h",
                     busy, req_ready, cu_enable, cu_data_in);
            n_bad++;
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_stream();
        test_single_requester();
        test_round_robin();
        test_gapped_burst();
        test_drain_timeout();
        test_output_and_single_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
